// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell evaluated once per
// clock, LSB first, across a WIDTH-bit operation. Operands are latched on an
// accepted start; the result is published with a one-cycle done pulse.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-2:0] sum_q;      // low result bits collected so far
    logic             carry_q;
    logic             c_msb_q;    // carry into the MSB, for signed overflow
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;

    logic             s;
    logic             carry_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] sum_nxt;

    // Single shared full-adder cell and the shifted partial result.
    always_comb begin
        s         = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        sum_nxt   = {s, sum_q};
        last_bit  = (count_q == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: operand latch, serial evaluation, result publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Subtraction as a + ~b + 1.
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub;
                        count_q <= '0;
                    end
                end
                StRun: begin
                    carry_q <= carry_nxt;
                    sum_q   <= sum_nxt[WIDTH-1:1];
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 2)) begin
                        c_msb_q <= carry_nxt;
                    end
                    if (last_bit) begin
                        result_q <= sum_nxt;
                        cout_q   <= carry_nxt;
                        ovf_q    <= c_msb_q ^ carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decoded straight from the state register.
    always_comb begin
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
        result   = result_q;
        cout     = cout_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl: a vector table of arithmetic cases
// plus hand-written sequences for ignored starts, mid-run reset and
// back-to-back operation.
module tb_serial_addsub_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t tbl[9];

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and check timing and results. Called at a negedge.
    task automatic run_op(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int bcnt;
        int lat;
        bit found;
        bcnt  = 0;
        lat   = 0;
        found = 0;
        start = 1'b1;
        sub   = s;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        sub   = ~s;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                found = 1;
                lat   = i;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("done_seen", 32'(found), 32'd1);
        // Edges counted from the acceptance edge inclusive.
        chk("done_latency", 32'(lat + 1), 32'(W + 1));
        chk("busy_cycles", 32'(bcnt), 32'(W));
        chk("result", 32'(result), 32'(er));
        chk("cout", 32'(cout), 32'(ec));
        chk("overflow", 32'(overflow), 32'(eo));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("result_hold", 32'(result), 32'(er));
    endtask

    initial begin
        int gap;
        int first;
        int ndone;

        tbl[0] = '{1'b0, 8'd100, 8'd55,  8'h9B, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'hFF,  8'h01,  8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'd5,   8'd3,   8'h02, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'd3,   8'd5,   8'hFE, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h80,  8'h01,  8'h7F, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h7F,  8'h01,  8'h80, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 8'h00,  8'h00,  8'h00, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h80,  8'h80,  8'h00, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 8'h7F,  8'hFF,  8'h80, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].co, tbl[i].ov);
        end

        // Starts during RUN and DONE are ignored.
        start = 1'b1; sub = 1'b0; a = 8'd10; b = 8'd20;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    chk("ign_result", 32'(result), 32'd30);
                    chk("ign_cout", 32'(cout), 32'd0);
                    start = 1'b1; a = 8'd1; b = 8'd1;
                end
            end
            if (i == 2) begin
                start = 1'b1; a = 8'd1; b = 8'd1;
            end
            if (first >= 0 && i > first) begin
                chk("ign_no_busy", 32'(busy), 32'd0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_latency", 32'(first + 1), 32'(W + 1));
        chk("ign_single_done", 32'(ndone), 32'd1);
        chk("ign_result_hold", 32'(result), 32'd30);

        // Reset on the 4th RUN cycle aborts with no done.
        start = 1'b1; sub = 1'b0; a = 8'd200; b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(ndone), 32'd0);
        run_op(1'b0, 8'd7, 8'd9, 8'd16, 1'b0, 1'b0);

        // Start held high: back-to-back operations every W+2 cycles.
        start = 1'b1; sub = 1'b0; a = 8'd1; b = 8'd2;
        first = -1;
        gap   = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b_result", 32'(result), 32'd3);
                if (first < 0) begin
                    first = i;
                end else if (gap < 0) begin
                    gap = i - first;
                end
            end
        end
        start = 1'b0;
        chk("b2b_period", 32'(gap), 32'(W + 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
